// File: rtl/bcd_key_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_key_arbiter
//
// Front end for the 8421 BCD digit encoder. Ten level-sensitive key request
// lines are registered once, one key is picked round-robin among the pressed
// ones, and that key is debounced for press and release. Each debounced
// press pushes the BCD code of the key into a small first-word-fall-through
// FIFO. A digit consumer drains the FIFO through a valid/ready handshake.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed for press and release (>= 2)
//   FIFO_DEPTH       digit queue depth (power of 2, >= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   key_in[9:0]  bit k high = decimal key k pressed
//   digit_out    BCD code at the FIFO head, 4'b0000 when the FIFO is empty
//   digit_valid  FIFO non-empty
//   digit_ready  consumer takes the head this cycle
//   fifo_count   number of entries held
//   overflow     one-cycle pulse when a debounced press is dropped (FIFO full)
//   dbg_state    current FSM state (0 idle, 1 debounce, 2 hold, 3 release)
//   dbg_rr_ptr   round-robin search start position (0..9)
//
// Handshake: a digit is transferred on every rising edge where digit_valid
// and digit_ready are both high. digit_valid stays high and digit_out stays
// stable until the transfer happens. digit_ready may change freely, and
// nothing on the output side depends on it combinationally.
// ---------------------------------------------------------------------------
module bcd_key_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    key_in,
  output logic [3:0]                    digit_out,
  output logic                          digit_valid,
  input  logic                          digit_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state,
  output logic [3:0]                    dbg_rr_ptr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Input register: every decision below is made on key_q.
  // -------------------------------------------------------------------------
  logic [9:0] key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
    end else begin
      key_q <= key_in;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first set bit of key_q at or above rr_ptr, wrapping
  // from 9 back to 0.
  // -------------------------------------------------------------------------
  logic [3:0] rr_ptr;
  logic [3:0] rr_grant;
  logic       rr_found;

  always_comb begin
    rr_found = 1'b0;
    rr_grant = 4'd0;
    for (int i = 0; i < 10; i++) begin
      logic [4:0] idx;
      idx = {1'b0, rr_ptr} + 5'(i);
      if (idx >= 5'd10) begin
        idx = idx - 5'd10;
      end
      if (!rr_found && key_q[idx[3:0]]) begin
        rr_found = 1'b1;
        rr_grant = idx[3:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    grant_q, grant_nxt;
  logic [3:0]    rr_ptr_nxt;
  logic          push_req;
  logic [3:0]    push_digit;
  logic          granted_high;

  assign granted_high = key_q[grant_q];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      grant_q <= 4'd0;
      rr_ptr  <= 4'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      grant_q <= grant_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    grant_nxt  = grant_q;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (rr_found) begin
          grant_nxt = rr_grant;
          cnt_nxt   = CW'(1);
          state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        // A press that bounces away is forgotten; the pointer is not moved.
        if (!granted_high) begin
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        // Other keys are ignored while the granted key is held.
        if (!granted_high) begin
          cnt_nxt   = CW'(1);
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A glitch back high resumes holding without producing a new digit.
        if (granted_high) begin
          state_nxt = ST_HOLD;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (grant_q == 4'd9) ? 4'd0 : grant_q + 4'd1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    push_req   = (state == ST_DEBOUNCE) && granted_high && (cnt == CNT_LAST);
    push_digit = grant_q;  // key index 0..9 is already its 8421 code
    dbg_state  = state;
    dbg_rr_ptr = rr_ptr;
  end

  // -------------------------------------------------------------------------
  // Digit FIFO (first-word fall-through)
  // -------------------------------------------------------------------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full    = (count == FIFO_FULL);
  assign pop     = digit_valid & digit_ready;
  // When full, a push still fits if the head leaves in the same cycle.
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_digit;
    end
  end

  assign digit_valid = (count != '0);
  assign digit_out   = digit_valid ? mem[rd_ptr] : 4'b0000;
  assign fifo_count  = count;

endmodule

// File: tb/tb_bcd_key_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_key_arbiter
//
// Drives directed scenarios and then random key patterns into
// bcd_key_arbiter. A behavioural model tracks press/release run lengths and
// keeps the expected digits in a queue. All DUT outputs are compared with
// the model one time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_key_arbiter;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_in = '0;
  logic       digit_ready = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic       overflow;
  logic [1:0] dbg_state;
  logic [3:0] dbg_rr_ptr;

  always #5 clk = ~clk;

  bcd_key_arbiter #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .dbg_state   (dbg_state),
    .dbg_rr_ptr  (dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy: a key is granted; pressed: its press has been accepted.
  // m_run counts consecutive high cycles during the press,
  // m_low counts consecutive low cycles after acceptance.
  logic [3:0] exp_q[$];
  logic [9:0] m_kq;
  bit         m_busy, m_pressed;
  int         m_g, m_ptr, m_run, m_low;
  logic       m_ovf;

  function automatic int rr_pick(input logic [9:0] k, input int start);
    for (int i = 0; i < 10; i++) begin
      if (k[(start + i) % 10]) return (start + i) % 10;
    end
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_kq = '0; m_busy = 0; m_pressed = 0;
    m_g = 0; m_ptr = 0; m_run = 0; m_low = 0; m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [9:0] k, input logic rdy);
    bit push, pop, full;
    if (rst) begin
      model_reset();
      return;
    end
    push = 0;
    if (!m_busy) begin
      if (m_kq != 0) begin
        m_g = rr_pick(m_kq, m_ptr);
        m_busy = 1; m_pressed = 0; m_run = 1;
      end
    end else if (!m_pressed) begin
      if (!m_kq[m_g]) m_busy = 0;
      else if (m_run == D - 1) begin push = 1; m_pressed = 1; m_low = 0; end
      else m_run++;
    end else begin
      if (m_kq[m_g]) m_low = 0;
      else if (m_low == D - 1) begin
        m_busy = 0; m_pressed = 0; m_ptr = (m_g + 1) % 10;
      end else m_low++;
    end
    pop   = (exp_q.size() != 0) && rdy;
    full  = (exp_q.size() == DEPTH);
    m_ovf = push && full && !pop;
    if (pop) void'(exp_q.pop_front());
    if (push && !m_ovf) exp_q.push_back(4'(m_g));
    m_kq = k;
  endtask

  function automatic int exp_state();
    if (!m_busy)    return 0;
    if (!m_pressed) return 1;
    if (m_low == 0) return 2;
    return 3;
  endfunction

  task automatic compare_all();
    check("digit_valid", digit_valid, exp_q.size() != 0);
    check("digit_out",   digit_out,   (exp_q.size() != 0) ? exp_q[0] : 4'd0);
    check("fifo_count",  fifo_count,  exp_q.size());
    check("overflow",    overflow,    m_ovf);
    check("state",       dbg_state,   exp_state());
    check("rr_ptr",      dbg_rr_ptr,  m_ptr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [9:0] k, input logic rdy);
    key_in = k;
    digit_ready = rdy;
    @(posedge clk);
    model_edge(k, rdy);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic hold(input logic [9:0] k, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(k, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(10'h0, 1'b0, 2);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] pat;
  int         len;
  int         sel;

  initial begin
    model_reset();
    // reset state
    hold(10'h0, 1'b0, 2);
    rst = 1'b0;

    // key 7 held 12 cycles, consumer stalled; then release and drain
    hold(10'h080, 1'b0, 12);
    hold(10'h000, 1'b0, 6);
    hold(10'h000, 1'b1, 2);

    // short press of key 3: no digit, pointer stays 0
    do_reset();
    hold(10'h008, 1'b0, 2);
    hold(10'h000, 1'b0, 6);

    // keys 2 and 5 together twice: 2 then 5
    do_reset();
    hold(10'h024, 1'b0, 8);
    hold(10'h000, 1'b0, 6);
    hold(10'h024, 1'b0, 8);
    hold(10'h000, 1'b0, 6);
    hold(10'h000, 1'b1, 3);

    // five presses into a depth-4 FIFO, then drain
    do_reset();
    hold(10'h002, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h004, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h008, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h010, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h040, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h000, 1'b1, 6);

    // full FIFO: push of key 8 coincides with a pop
    do_reset();
    hold(10'h002, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h004, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h008, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h010, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h100, 1'b0, 4);
    step(10'h100, 1'b1);
    hold(10'h100, 1'b0, 2);
    hold(10'h000, 1'b0, 6);
    hold(10'h000, 1'b1, 6);

    // reset during debounce of key 9 with digits queued
    do_reset();
    hold(10'h001, 1'b0, 6); hold(10'h000, 1'b0, 6);
    hold(10'h200, 1'b0, 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    hold(10'h000, 1'b0, 3);
    rst = 1'b0;
    hold(10'h000, 1'b1, 10);

    // key held through reset deassertion counts as a new press
    rst = 1'b1;
    hold(10'h010, 1'b0, 2);
    rst = 1'b0;
    hold(10'h010, 1'b0, 8);
    hold(10'h000, 1'b1, 8);

    // randomized key patterns and consumer stalls
    do_reset();
    repeat (200) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)      pat = 10'd1 << $urandom_range(0, 9);
      else if (sel < 7) pat = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
      else if (sel < 9) pat = 10'h000;
      else              pat = 10'($urandom_range(0, 1023));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) step(pat, $urandom_range(0, 3) == 0);
    end
    hold(10'h000, 1'b1, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_key_arbiter.md
# bcd_key_arbiter

Front-end controller for the 8421 BCD digit encoder. It samples ten decimal key request lines, arbitrates round-robin among simultaneous presses, and debounces the granted key for press and release. Each accepted keypress is encoded to 8421 BCD and queued in a small first-word-fall-through FIFO, drained through a valid/ready handshake. It sits between raw key inputs and any digit consumer (display, accumulator).

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required for press and release; legal range ≥2.
- FIFO_DEPTH, 4: digit queue depth; power of 2, ≥2.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  10  level request; bit k high = decimal key k pressed.
- digit_out  out  4  8421 BCD of FIFO head; 4'b0000 when empty.
- digit_valid  out  1  FIFO non-empty.
- digit_ready  in  1  consumer accepts head when digit_valid & digit_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  one-cycle pulse when an accepted keypress is dropped because FIFO is full.

## Operation
- Reset values: digit_out=0, digit_valid=0, fifo_count=0, overflow=0; FSM=IDLE; rr pointer=0; key_in_q=0; FIFO empty.
- key_in registered once into key_in_q; all decisions use key_in_q.
- Round-robin: search key_in_q from pointer upward, wrapping 9→0; first set bit is granted key g. Pointer updates only on completed release (to (g+1) mod 10); aborted presses leave it unchanged.
- FSM (counter cnt, width ≥ $clog2(DEBOUNCE_CYCLES)+1):
  - IDLE: if key_in_q≠0 → grant g, cnt←1, DEBOUNCE.
  - DEBOUNCE: key_in_q[g]=0 → IDLE (no push). Else if cnt=DEBOUNCE_CYCLES−1 → push BCD(g), HOLD. Else cnt++.
  - HOLD: key_in_q[g]=0 → cnt←1, RELEASE. Other keys ignored.
  - RELEASE: key_in_q[g]=1 → HOLD (no new push). Else if cnt=DEBOUNCE_CYCLES−1 → IDLE, pointer update. Else cnt++.
- BCD(g) = 4-bit binary of g (0→0000 … 9→1001).
- FIFO: pop when digit_valid & digit_ready. Push when full and no pop same cycle → entry dropped, overflow=1 that cycle, FIFO unchanged. Push and pop in same cycle when full → both occur, count unchanged, no overflow. Push and pop same cycle when empty → not a bypass; push lands, count 0→1.
- Pointers wrap modulo FIFO_DEPTH; order strictly first-in-first-out.
- rst mid-operation: immediate clear of all state and outputs; partial press discarded; key held through reset deassertion is treated as a new press.

## Timing
- key_in[k] first sampled high at edge E0 and held, FIFO empty: grant at E1, push at E0+DEBOUNCE_CYCLES; digit_valid and digit_out valid after that edge.
- digit_out/digit_valid/fifo_count registered (or combinational from registered FIFO state only); no combinational path from key_in or digit_ready to outputs.
- Pop on edge with digit_valid&digit_ready; next head visible after that edge.
- Minimum cycles between two accepted presses of one key: 2·DEBOUNCE_CYCLES.
- overflow asserted exactly one cycle, after the edge where the drop occurs.

## Test plan
- D=4, key 7 held 12 cycles from E0, digit_ready=0 → single push after E4, digit_out=0111, fifo_count=1; release → no further push, FSM IDLE after release debounce.
- Key 3 high 2 cycles then low → no push, fifo_count=0, pointer remains 0.
- After reset keys 2 and 5 held together → 0010 pushed; release both, press both again → pointer=3, 0101 pushed.
- digit_ready=0, five distinct accepted presses (1,2,3,4,6) with depth 4 → fifo_count=4, overflow pulses once at fifth push; draining yields 0001,0010,0011,0100.
- FIFO full, push coincides with pop → fifo_count stays 4, overflow=0, new digit last in order.
- rst asserted during DEBOUNCE of key 9 → all outputs 0 immediately; key released before rst drops → no digit ever produced.
